// File: rtl/bit_serial_adder_seq.sv
// Bit-serial adder sequencer around a single full-adder cell.
// Feeds operand bits LSB-first, waits a settle window, captures sum and carry.
module bit_serial_adder_seq #(
  parameter int W          = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin_init,
  input  logic         fa_sum,
  input  logic         fa_cout,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPT,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   res_q, res_d;
  logic           cout_q, cout_d;
  logic           fa_a_q, fa_a_d;
  logic           fa_b_q, fa_b_d;
  logic           fa_cin_q, fa_cin_d;
  logic           drive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == '0) state_d = S_CAPT;
      S_CAPT: begin
        if (idx_q == IW'(W-1)) state_d = S_DONE;
        else                   state_d = S_SETTLE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_IDLE:   busy = 1'b0;
      S_SETTLE: busy = 1'b1;
      S_CAPT:   busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin_init;
          idx_d   = '0;
          cnt_d   = CW'(SETTLE_CYC-1);
          res_d   = '0;
          cout_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      S_CAPT: begin
        res_d[idx_q] = fa_sum;
        carry_d      = fa_cout;
        if (idx_q == IW'(W-1)) begin
          cout_d = fa_cout;
        end else begin
          idx_d = idx_q + 1'b1;
          cnt_d = CW'(SETTLE_CYC-1);
        end
      end
      S_DONE:  cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  // Cell drive is computed from next-state values so the flops line up
  // with the state they belong to and never glitch.
  always_comb begin
    drive    = (state_d == S_SETTLE) || (state_d == S_CAPT);
    fa_a_d   = drive & a_d[idx_d];
    fa_b_d   = drive & b_d[idx_d];
    fa_cin_d = drive & carry_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      fa_a_q   <= 1'b0;
      fa_b_q   <= 1'b0;
      fa_cin_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      fa_a_q   <= fa_a_d;
      fa_b_q   <= fa_b_d;
      fa_cin_q <= fa_cin_d;
    end
  end

  assign fa_a   = fa_a_q;
  assign fa_b   = fa_b_q;
  assign fa_cin = fa_cin_q;
  assign result = res_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_bit_serial_adder_seq.sv
// Bench for bit_serial_adder_seq: delayed behavioural full-adder cell
// plus a scoreboard of expected {cout,result} popped on each done pulse.
module tb_bit_serial_adder_seq;

  localparam int W   = 8;
  localparam int SC  = 2;
  localparam int LAT = W*(SC+1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin_init;
  logic         fa_sum;
  logic         fa_cout;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  bit_serial_adder_seq #(.W(W), .SETTLE_CYC(SC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin_init (cin_init),
    .fa_sum   (fa_sum),
    .fa_cout  (fa_cout),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_done = 0;
  int cell_dly = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Full-adder cell with a configurable delay in clock cycles.
  logic [1:0] pipe [8] = '{default: 2'b00};
  always @(posedge clk) begin
    pipe[0] <= {fa_a ^ fa_b ^ fa_cin,
                (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin)};
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end
  always_comb {fa_sum, fa_cout} = pipe[cell_dly-1];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W:0] exp;
    bit         fault;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      chk("done_busy", 32'(busy), 32'd1);
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.fault) begin
          chk("fault_seen", 32'({cout, result} !== mon_e.exp), 32'd1);
        end else begin
          chk("result", 32'(result), 32'(mon_e.exp[W-1:0]));
          chk("cout", 32'(cout), 32'(mon_e.exp[W]));
          chk("latency", 32'(cyc - acc_cyc), 32'(LAT));
        end
      end
    end
  end

  task automatic start_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input bit fault);
    sb_t e;
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    cin_init = c;
    start    = 1'b1;
    e.exp    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.fault  = fault;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start   = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 4*LAT && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
    start_add(a, b, c, 1'b0);
    wait_done();
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_drive", 32'({fa_a, fa_b, fa_cin}), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({busy, done, cout, fa_a, fa_b, fa_cin, result}), 32'd0);
  endtask

  int nd0;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    cin_init = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset_outs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_add(8'hA5, 8'h3C, 1'b0);
    repeat (5) @(negedge clk);
    chk("hold_result", 32'(result), 32'hE1);
    run_add(8'hFF, 8'h01, 1'b0);
    run_add(8'h00, 8'h00, 1'b1);
    run_add(8'hFF, 8'hFF, 1'b1);
    for (int r = 0; r < 4; r++)
      run_add(W'($urandom), W'($urandom), 1'($urandom));

    // Starts while busy and during DONE must be dropped.
    nd0 = n_done;
    start_add(8'h0F, 8'h0F, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    op_a  = 8'h77;
    op_b  = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    op_a  = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after", 32'(busy), 32'd0);
    repeat (3*LAT/2) @(negedge clk);
    chk("one_done", 32'(n_done - nd0), 32'd1);
    chk("still_idle", 32'(busy), 32'd0);
    chk("held_first", 32'(result), 32'h1E);

    // Abort in the middle of bit 4.
    start_add(8'hA5, 8'h3C, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_partial", 32'(result), 32'h01);
    nd0 = n_done;
    rst_n = 1'b0;
    #1;
    chk_zero("abort_outs");
    void'(sb_q.pop_front());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2*LAT) @(negedge clk);
    chk("abort_no_done", 32'(n_done - nd0), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    run_add(8'h12, 8'h34, 1'b0);

    // Cell slower than the settle window must corrupt the sum.
    cell_dly = 4;
    start_add(8'hA5, 8'h3C, 1'b0, 1'b1);
    wait_done();
    cell_dly = 1;
    repeat (10) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
